// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown sequencer and its tick prescaler.
package countdown_pkg;

  typedef enum logic [2:0] {IDLE, ZERO, LOAD, RUN, DONE} countdown_state_t;

  // Prescaler register width: max(1, clog2(prescale)).
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/countdown_sequencer_tick_prescaler.sv
// Free-running tick divider: one tick every PRESCALE cycles while run is high,
// restarted from zero by clear. Reusable by other timers.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (run) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tick = run && (count_reg == LAST);

endmodule

// File: rtl/countdown_sequencer.sv
// Timeout engine driving an external down-counter: load, prescaled decrement, done pulse.
// Optional auto-reload loop enabled by defining COUNTDOWN_PERIODIC_EN.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] duration,
  input  logic             periodic,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_y,
  output logic [WIDTH-1:0] cnt_x,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  countdown_state_t state_reg, state_next, after_done;

  logic [WIDTH-1:0] cnt_x_reg;
  logic             periodic_reg;
  logic             aborted_reg;
  logic             accept;
  logic             cnt_zero;
  logic             abort_kill;
  logic             tick;

  assign accept     = start_valid && (state_reg == IDLE);
  assign cnt_zero   = (cnt_y == '0);
  // An abort landing on DONE lets done stand and raises no aborted pulse.
  assign abort_kill = abort && (state_reg inside {ZERO, LOAD, RUN});

`ifdef COUNTDOWN_PERIODIC_EN
  assign after_done = periodic_reg ? ((cnt_x_reg == '0) ? ZERO : LOAD) : IDLE;
`else
  logic periodic_unused;
  assign periodic_unused = periodic_reg;
  assign after_done      = IDLE;
`endif

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_reg == LOAD),
    .run    (state_reg == RUN),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_x_reg    <= '0;
      periodic_reg <= 1'b0;
      aborted_reg  <= 1'b0;
    end else begin
      aborted_reg <= abort_kill;
      if (accept) begin
        cnt_x_reg    <= duration;
        periodic_reg <= periodic;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start_valid) state_next = (duration == '0) ? ZERO : LOAD;
      ZERO:    state_next = DONE;
      LOAD:    state_next = RUN;
      RUN:     if (cnt_zero) state_next = DONE;
      DONE:    state_next = after_done;
      default: state_next = IDLE;
    endcase
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    done        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      LOAD:    cnt_load = 1'b1;
      RUN:     cnt_en   = tick && !cnt_zero;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  assign cnt_x   = cnt_x_reg;
  assign aborted = aborted_reg;

endmodule
